// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter and shadowed period/duty/mode registers.
// Optional feature: define PWM_MULTI_INVERT_EN to add a per-channel output polarity mask.
module pwm_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] out,
    output logic                period_end
);

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic             sh_en;
    logic             sh_center;
    logic [WIDTH-1:0] sh_period;
    logic [WIDTH-1:0] sh_duty [CHANNELS];

    logic             sh_en_nxt;
    logic             sh_center_nxt;
    logic [WIDTH-1:0] sh_period_nxt;
    logic [WIDTH-1:0] sh_duty_nxt [CHANNELS];

    logic             act_en;
    logic             act_center;
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] act_duty [CHANNELS];

    logic [WIDTH-1:0] counter;
    dir_t             dir;

    logic [WIDTH-1:0]    counter_nxt;
    dir_t                dir_nxt;
    logic [WIDTH-1:0]    last_count;
    logic                boundary;
    logic [CHANNELS-1:0] duty_hit;
    logic [CHANNELS-1:0] act_mask;

`ifdef PWM_MULTI_INVERT_EN
    // The mask register only exists when its address does not alias CTRL after truncation.
    localparam bit                MASK_ADDR_OK = (2 + CHANNELS) < (1 << ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK    = ADDR_W'(2 + CHANNELS);

    logic [CHANNELS-1:0] sh_mask;
    logic [CHANNELS-1:0] sh_mask_nxt;
    logic [CHANNELS-1:0] act_mask_q;

    assign act_mask = act_mask_q;

    always_comb begin
        sh_mask_nxt = sh_mask;
        if (wr && MASK_ADDR_OK && (wr_addr == ADDR_MASK)) begin
            sh_mask_nxt = wr_data[CHANNELS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_mask    <= '0;
            act_mask_q <= '0;
        end else begin
            sh_mask <= sh_mask_nxt;
            if (boundary) begin
                act_mask_q <= sh_mask_nxt;
            end
        end
    end
`else
    assign act_mask = '0;
`endif

    // Shadow next-values; a write landing on a boundary is part of that commit.
    always_comb begin
        sh_en_nxt     = sh_en;
        sh_center_nxt = sh_center;
        sh_period_nxt = sh_period;
        sh_duty_nxt   = sh_duty;
        if (wr) begin
            if (wr_addr == ADDR_CTRL) begin
                sh_en_nxt     = wr_data[0];
                sh_center_nxt = wr_data[1];
            end
            if (wr_addr == ADDR_PERIOD) begin
                sh_period_nxt = wr_data;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_addr == ADDR_W'(2 + k)) begin
                    sh_duty_nxt[k] = wr_data;
                end
            end
        end
    end

    // P=0 behaves like P=1 in both modes, so the top count is never below zero.
    assign last_count = (act_period == '0) ? '0 : act_period - WIDTH'(1);

    always_comb begin
        boundary = 1'b1;
        if (act_en) begin
            if (act_center) begin
                boundary = (counter == '0) && (dir == DIR_DOWN);
            end else begin
                boundary = (counter >= last_count);
            end
        end
    end

    always_comb begin
        counter_nxt = counter;
        dir_nxt     = dir;
        if (!act_en || boundary) begin
            counter_nxt = '0;
            dir_nxt     = DIR_UP;
        end else if (!act_center) begin
            counter_nxt = counter + WIDTH'(1);
        end else if (dir == DIR_UP) begin
            if (counter >= last_count) begin
                dir_nxt = DIR_DOWN;
            end else begin
                counter_nxt = counter + WIDTH'(1);
            end
        end else begin
            counter_nxt = counter - WIDTH'(1);
        end
    end

    always_comb begin
        duty_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            duty_hit[k] = (counter < act_duty[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_en      <= 1'b0;
            sh_center  <= 1'b0;
            sh_period  <= '0;
            act_en     <= 1'b0;
            act_center <= 1'b0;
            act_period <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                sh_duty[k]  <= '0;
                act_duty[k] <= '0;
            end
            counter    <= '0;
            dir        <= DIR_UP;
            out        <= '0;
            period_end <= 1'b0;
        end else begin
            sh_en     <= sh_en_nxt;
            sh_center <= sh_center_nxt;
            sh_period <= sh_period_nxt;
            sh_duty   <= sh_duty_nxt;
            if (boundary) begin
                act_en     <= sh_en_nxt;
                act_center <= sh_center_nxt;
                act_period <= sh_period_nxt;
                act_duty   <= sh_duty_nxt;
            end
            counter    <= counter_nxt;
            dir        <= dir_nxt;
            // The idle level follows the polarity mask, which is all-zero without inversion.
            out        <= act_en ? (duty_hit ^ act_mask) : act_mask;
            period_end <= act_en && boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a period-phase model compared on every cycle, plus directed
// per-period high-count and pulse-count checks with hand-computed values.
module tb_pwm_multi;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int ADDR_W   = 5;
`ifdef PWM_MULTI_INVERT_EN
    localparam int INV = 1;
`else
    localparam int INV = 0;
`endif

    logic                clk        = 1'b0;
    logic                reset      = 1'b1;
    logic                wr         = 1'b0;
    logic [ADDR_W-1:0]   wr_addr    = '0;
    logic [WIDTH-1:0]    wr_data    = '0;
    logic [CHANNELS-1:0] out;
    logic                period_end;

    int tests = 0;
    int fails = 0;
    int highs [CHANNELS];
    int pes;

    pwm_multi #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr(wr),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .out(out),
        .period_end(period_end)
    );

    always #5 clk = ~clk;

    // Model state: active/shadow settings and the position within the current period.
    logic                mEn, mCenter, sEn, sCenter;
    int                  mPeriod, sPeriod;
    int                  mDuty [CHANNELS];
    int                  sDuty [CHANNELS];
    logic [CHANNELS-1:0] mMask, sMask;
    int                  phase;
    logic [CHANNELS-1:0] expOut;
    logic                expPe;
    logic                modelValid = 1'b0;

    always @(posedge clk) begin : model
        int   pEff, len, c, a;
        logic bnd;
        if (reset) begin
            mEn = 1'b0; mCenter = 1'b0; sEn = 1'b0; sCenter = 1'b0;
            mPeriod = 0; sPeriod = 0; mMask = '0; sMask = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                mDuty[k] = 0;
                sDuty[k] = 0;
            end
            phase  = 0;
            expOut = '0;
            expPe  = 1'b0;
        end else begin
            pEff = (mPeriod == 0) ? 1 : mPeriod;
            len  = mCenter ? 2 * pEff : pEff;
            c    = (!mCenter || phase < pEff) ? phase : 2 * pEff - 1 - phase;
            bnd  = !mEn || (phase == len - 1);
            for (int k = 0; k < CHANNELS; k++) begin
                expOut[k] = mEn ? ((c < mDuty[k]) ^ mMask[k]) : mMask[k];
            end
            expPe = mEn && bnd;
            if (wr) begin
                a = int'(wr_addr);
                if (a == 0) begin
                    sEn     = wr_data[0];
                    sCenter = wr_data[1];
                end else if (a == 1) begin
                    sPeriod = int'(wr_data);
                end else if (a >= 2 && a < 2 + CHANNELS) begin
                    sDuty[a - 2] = int'(wr_data);
                end else if (INV == 1 && a == 2 + CHANNELS) begin
                    sMask = wr_data[CHANNELS-1:0];
                end
            end
            if (bnd) begin
                mEn = sEn; mCenter = sCenter; mPeriod = sPeriod; mMask = sMask;
                mDuty = sDuty;
                phase = 0;
            end else begin
                phase++;
            end
        end
        modelValid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("cycle_out", int'(out), int'(expOut));
            checkOutput("cycle_period_end", int'(period_end), int'(expPe));
        end
    end

    // One cycle: sample outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic applyStimulus(input logic doWr, input int addr, input int data);
        @(negedge clk);
        for (int k = 0; k < CHANNELS; k++) begin
            highs[k] += int'(out[k]);
        end
        pes += int'(period_end);
        wr      = doWr;
        wr_addr = ADDR_W'(addr);
        wr_data = WIDTH'(data);
    endtask

    task automatic runCycles(input int n, input int wrIdx, input int addr, input int data);
        for (int i = 0; i < n; i++) begin
            applyStimulus(i == wrIdx, addr, data);
        end
    endtask

    task automatic resetCounts();
        for (int k = 0; k < CHANNELS; k++) begin
            highs[k] = 0;
        end
        pes = 0;
    endtask

    task automatic waitPeriodEnd();
        int n = 0;
        do begin
            applyStimulus(1'b0, 0, 0);
            n++;
        end while (period_end !== 1'b1 && n < 200);
        if (period_end !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_period_end: no pulse within %0d cycles", n);
        end
    endtask

    initial begin
        resetCounts();
        repeat (3) @(negedge clk);
        checkOutput("reset_out", int'(out), 0);
        checkOutput("reset_period_end", int'(period_end), 0);
        reset = 1'b0;

        // Edge mode, P=10 with duties 3/0/10/15.
        applyStimulus(1'b1, 1, 10);
        applyStimulus(1'b1, 2, 3);
        applyStimulus(1'b1, 3, 0);
        applyStimulus(1'b1, 4, 10);
        applyStimulus(1'b1, 5, 15);
        applyStimulus(1'b1, 0, 1);
        waitPeriodEnd();
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("edge_out0_high", highs[0], 3);
        checkOutput("edge_out1_high", highs[1], 0);
        checkOutput("edge_out2_high", highs[2], 10);
        checkOutput("edge_out3_high", highs[3], 10);
        checkOutput("edge_pulses", pes, 1);

        // Mid-period duty write shows up only in the following period.
        waitPeriodEnd();
        resetCounts();
        runCycles(10, 2, 2, 7);
        checkOutput("shadow_mid_current", highs[0], 3);
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("shadow_mid_next", highs[0], 7);

        // Write on the boundary cycle joins that commit.
        waitPeriodEnd();
        resetCounts();
        runCycles(10, 8, 2, 5);
        checkOutput("shadow_bnd_current", highs[0], 7);
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("shadow_bnd_next", highs[0], 5);

        // Edge-to-center switch mid-period, deferred to the boundary.
        resetCounts();
        runCycles(10, 3, 2, 2);
        checkOutput("pre_switch_out0", highs[0], 5);
        resetCounts();
        runCycles(3, 1, 1, 8);
        runCycles(7, 1, 0, 3);
        checkOutput("switch_deferred_out0", highs[0], 2);
        checkOutput("switch_deferred_pulses", pes, 1);
        resetCounts();
        runCycles(16, -1, 0, 0);
        checkOutput("center_out0_high", highs[0], 4);
        checkOutput("center_pulses", pes, 1);

        // Back to edge mode, then disable at count 4.
        runCycles(6, 1, 1, 10);
        runCycles(2, 0, 0, 1);
        waitPeriodEnd();
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("back_to_edge_out0", highs[0], 2);
        resetCounts();
        runCycles(10, 3, 0, 0);
        checkOutput("disable_completes_out0", highs[0], 2);
        checkOutput("disable_completes_pulses", pes, 1);
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("disabled_out_low", highs[0] + highs[2] + highs[3], 0);
        checkOutput("disabled_no_pulses", pes, 0);
        applyStimulus(1'b1, 2, 5);
        applyStimulus(1'b1, 0, 1);
        waitPeriodEnd();
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("reenable_duty5", highs[0], 5);

        // Reset at count 6 with D0=8 and a pending D1 write.
        runCycles(10, 0, 2, 8);
        runCycles(3, 1, 3, 4);
        runCycles(2, -1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        wr    = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out", int'(out), 0);
        checkOutput("midreset_period_end", int'(period_end), 0);
        reset = 1'b0;
        applyStimulus(1'b1, 0, 1);
        runCycles(1, -1, 0, 0);
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("after_reset_out_zero", highs[0] + highs[1] + highs[2] + highs[3], 0);
        checkOutput("after_reset_p0_pulses", pes, 10);

        // Polarity mask (ignored address when the feature is absent).
        applyStimulus(1'b1, 0, 0);
        applyStimulus(1'b1, 2 + CHANNELS, 1);
        applyStimulus(1'b1, 1, 10);
        applyStimulus(1'b1, 2, 3);
        runCycles(2, -1, 0, 0);
        checkOutput("idle_level", int'(out), INV);
        applyStimulus(1'b1, 0, 1);
        waitPeriodEnd();
        resetCounts();
        runCycles(10, -1, 0, 0);
        checkOutput("mask_out0_high", highs[0], INV == 1 ? 7 : 3);
        checkOutput("pending_write_lost", highs[1], 0);
        applyStimulus(1'b1, 0, 0);
        waitPeriodEnd();
        runCycles(2, -1, 0, 0);
        checkOutput("idle_level_after_disable", int'(out), INV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
